// File: rtl/color_index_decode_if.sv
// color_index_decode_if
// Groups the pixel input stream and the decoded output stream of
// color_index_decode.
//   in_*  : RGB pixel input with valid/ready handshake and start-of-frame
//   out_* : decoded index beat with valid/ready handshake
// master: the side that supplies pixels and consumes decoded beats.
// slave : the decoder itself.
interface color_index_decode_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_sof;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic [7:0] out_h;
  logic       out_mismatch;
  logic [7:0] out_spread;

  modport master (
    output in_valid, in_sof, in_r, in_g, in_b, out_ready,
    input  in_ready, out_valid, out_sof, out_h, out_mismatch, out_spread
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_g, in_b, out_ready,
    output in_ready, out_valid, out_sof, out_h, out_mismatch, out_spread
  );
endinterface

// File: rtl/color_index_decode.sv
// color_index_decode
// Inverts the pseudo-color map (R = H, G = folded 2H, B = ~H) back to the
// 8-bit index H. Three channel estimates are formed, sorted, and the median
// is emitted; the spread (max - min) flags pixels that are not map colors.
// A per-frame mismatch counter supports loopback self-check.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   pix         : pixel in / decoded beat out stream (slave side)
//   err_count_o : mismatches so far in the current frame (saturating)
//   err_frame_o : final mismatch count of the previous frame
module color_index_decode #(
  parameter int TOL   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  color_index_decode_if.slave  pix,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [CNT_W-1:0]     err_frame_o
);

  localparam logic [7:0] TOL_B = TOL[7:0];

  logic             en;

  logic             v1_q, sof1_q;
  logic [7:0]       hr_q, hg_q, hb_q;
  logic [7:0]       hg_d;

  logic             v2_q, sof2_q;
  logic [7:0]       med_q, max_q, min_q;
  logic [7:0]       lo_ab, hi_ab, med_d, max_d, min_d;
  logic [7:0]       spread_d;

  logic             v3_q, sof3_q, mis3_q;
  logic [7:0]       h3_q, spread3_q;

  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] err_frame_q, err_frame_d;

  // Whole pipeline advances together; stalls only when the output beat is held.
  assign en           = !v3_q || pix.out_ready;
  assign pix.in_ready = en;

  // Green carries 2H, folded (inverted) when H[7] is set; the LSB of the
  // stored value tells which half we are in.
  assign hg_d = pix.in_g[0] ? {1'b1, ~pix.in_g[7:1]} : {1'b0, pix.in_g[7:1]};

  always_comb begin
    lo_ab = (hr_q < hg_q) ? hr_q : hg_q;
    hi_ab = (hr_q < hg_q) ? hg_q : hr_q;
    max_d = (hi_ab > hb_q) ? hi_ab : hb_q;
    min_d = (lo_ab < hb_q) ? lo_ab : hb_q;
    if (hb_q > hi_ab) begin
      med_d = hi_ab;
    end else if (hb_q < lo_ab) begin
      med_d = lo_ab;
    end else begin
      med_d = hb_q;
    end
  end

  assign spread_d = max_q - min_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      sof1_q    <= 1'b0;
      hr_q      <= '0;
      hg_q      <= '0;
      hb_q      <= '0;
      v2_q      <= 1'b0;
      sof2_q    <= 1'b0;
      med_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      v3_q      <= 1'b0;
      sof3_q    <= 1'b0;
      mis3_q    <= 1'b0;
      h3_q      <= '0;
      spread3_q <= '0;
    end else if (en) begin
      v1_q      <= pix.in_valid;
      sof1_q    <= pix.in_valid && pix.in_sof;
      hr_q      <= pix.in_r;
      hg_q      <= hg_d;
      hb_q      <= ~pix.in_b;
      v2_q      <= v1_q;
      sof2_q    <= sof1_q;
      med_q     <= med_d;
      max_q     <= max_d;
      min_q     <= min_d;
      v3_q      <= v2_q;
      sof3_q    <= sof2_q;
      h3_q      <= med_q;
      spread3_q <= spread_d;
      // Bubbles never report a mismatch.
      mis3_q    <= v2_q && (spread_d > TOL_B);
    end
  end

  // The sof beat opens the new frame: snapshot the old count and restart
  // from this beat's own mismatch.
  always_comb begin
    err_count_d = err_count_q;
    err_frame_d = err_frame_q;
    if (v3_q && pix.out_ready) begin
      if (sof3_q) begin
        err_frame_d = err_count_q;
        err_count_d = CNT_W'(mis3_q);
      end else if (mis3_q && (err_count_q != '1)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
      err_frame_q <= '0;
    end else begin
      err_count_q <= err_count_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign pix.out_valid    = v3_q;
  assign pix.out_sof      = sof3_q;
  assign pix.out_h        = h3_q;
  assign pix.out_spread   = spread3_q;
  assign pix.out_mismatch = mis3_q;
  assign err_count_o      = err_count_q;
  assign err_frame_o      = err_frame_q;

endmodule

// File: tb/tb_color_index_decode.sv
// Bench for color_index_decode: directed vectors with literal expectations,
// plus a per-cycle compare against an arithmetic model of the inverse map.
module tb_color_index_decode;
  localparam int TOL   = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] err_frame;

  color_index_decode_if bus ();

  color_index_decode #(.TOL(TOL), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix         (bus),
    .err_count_o (err_count),
    .err_frame_o (err_frame)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit bp_en = 1'b0;

  typedef struct {
    int h;
    int sp;
    int mis;
    int sof;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt = 0;
  int   m_frm = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Model: each channel is an estimate of H; median is the answer, the
  // range of the three estimates measures how far off the map we are.
  function automatic exp_t model(input int r, input int g, input int b, input int sof);
    exp_t e;
    int   est[3];
    est[0] = r;
    est[1] = (g % 2 == 1) ? 255 - g / 2 : g / 2;
    est[2] = 255 - b;
    est.sort();
    e.h   = est[1];
    e.sp  = est[2] - est[0];
    e.mis = (e.sp > TOL) ? 1 : 0;
    e.sof = sof;
    return e;
  endfunction

  // Backpressure generator
  always @(posedge clk) begin
    #1;
    if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Per-cycle compare process
  bit       prev_stall = 1'b0;
  logic [7:0] p_h, p_sp;
  logic     p_mis, p_sof;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      m_cnt      = 0;
      m_frm      = 0;
      prev_stall = 1'b0;
    end else begin
      chk("err_count", int'(err_count), m_cnt);
      chk("err_frame", int'(err_frame), m_frm);
      chk("in_ready", int'(bus.in_ready), (bus.out_valid && !bus.out_ready) ? 0 : 1);
      if (prev_stall) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_h", int'(bus.out_h), int'(p_h));
        chk("hold_spread", int'(bus.out_spread), int'(p_sp));
        chk("hold_mis", int'(bus.out_mismatch), int'(p_mis));
        chk("hold_sof", int'(bus.out_sof), int'(p_sof));
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_r, bus.in_g, bus.in_b, int'(bus.in_sof)));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_h", int'(bus.out_h), e.h);
          chk("out_spread", int'(bus.out_spread), e.sp);
          chk("out_mismatch", int'(bus.out_mismatch), e.mis);
          chk("out_sof", int'(bus.out_sof), e.sof);
          if (e.sof != 0) begin
            m_frm = m_cnt;
            m_cnt = e.mis;
          end else if (e.mis != 0 && m_cnt < SAT) begin
            m_cnt++;
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      p_h   = bus.out_h;
      p_sp  = bus.out_spread;
      p_mis = bus.out_mismatch;
      p_sof = bus.out_sof;
    end
  end

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic sof);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_r     = r;
    bus.in_g     = g;
    bus.in_b     = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic send_h(input int h, input logic sof);
    logic [7:0] hv;
    hv = 8'(h);
    send(hv, hv[7] ? ~{hv[6:0], 1'b0} : {hv[6:0], 1'b0}, ~hv, sof);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single pixel with literal expectations and latency check.
  task automatic single(input string name, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input int eh, input int es, input int em);
    send(r, g, b, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, "_early"}, int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_h"}, int'(bus.out_h), eh);
    chk({name, "_spread"}, int'(bus.out_spread), es);
    chk({name, "_mis"}, int'(bus.out_mismatch), em);
    idle(2);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_r      = '0;
    bus.in_g      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_h", int'(bus.out_h), 0);
    chk("rst_out_spread", int'(bus.out_spread), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_err_frame", int'(err_frame), 0);
    rst = 1'b0;
    idle(2);

    single("spot00", 8'h00, 8'h00, 8'hFF, 8'h00, 0, 0);
    single("spot80", 8'h80, 8'hFF, 8'h7F, 8'h80, 0, 0);
    single("spotC5", 8'hC5, 8'h75, 8'h3A, 8'hC5, 0, 0);
    single("corrupt", 8'h50, 8'h20, 8'hEF, 8'h10, 8'h40, 1);
    single("tol_eq", 8'h14, 8'h20, 8'hEF, 8'h10, 4, 0);
    single("tol_over", 8'h15, 8'h20, 8'hEF, 8'h10, 5, 1);

    // Clean sweep, back-to-back
    for (int h = 0; h < 256; h++) send_h(h, h == 0);
    idle(5);
    chk("sweep_err_count", int'(err_count), 0);

    // Frame accounting
    send_h(8'h20, 1'b1);
    send(8'h50, 8'h20, 8'hEF, 1'b0);
    send_h(8'h33, 1'b0);
    send(8'h50, 8'h20, 8'hEF, 1'b0);
    send(8'h15, 8'h20, 8'hEF, 1'b0);
    send_h(8'h44, 1'b0);
    send(8'h50, 8'h20, 8'hEF, 1'b1);
    idle(5);
    chk("frameB_err_frame", int'(err_frame), 3);
    chk("frameB_err_count", int'(err_count), 1);

    // Saturation
    for (int i = 0; i < (1 << CNT_W) + 5; i++) send(8'h50, 8'h20, 8'hEF, 1'b0);
    idle(5);
    chk("sat_err_count", int'(err_count), SAT);
    send_h(8'h01, 1'b1);
    idle(5);
    chk("sat_err_frame", int'(err_frame), SAT);
    chk("sat_new_count", int'(err_count), 0);

    // Backpressure run
    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 7 == 3)
        send(8'($urandom), 8'($urandom), 8'($urandom), i % 100 == 0);
      else
        send_h(int'($urandom_range(0, 255)), i % 100 == 0);
    end
    bus.in_valid = 1'b0;
    bp_en = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle(6);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with three pixels in flight and output stalled
    bus.out_ready = 1'b0;
    send_h(8'h11, 1'b1);
    send(8'h50, 8'h20, 8'hEF, 1'b0);
    send_h(8'h22, 1'b0);
    bus.in_valid = 1'b0;
    chk("full_in_ready", int'(bus.in_ready), 0);
    chk("full_out_valid", int'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_in_ready", int'(bus.in_ready), 1);
    chk("arst_err_count", int'(err_count), 0);
    chk("arst_err_frame", int'(err_frame), 0);
    chk("arst_out_mis", int'(bus.out_mismatch), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("stale_beat", seen, 0);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/color_index_decode.md
# color_index_decode

Streaming inverse of the pseudo-color map used on the disparity display path. It takes RGB pixels, recovers the 8-bit index H that produced them, and flags pixels that are not valid map colors. It also keeps a per-frame mismatch count for self-check.

It sits after the color-map stage, or after any RGB capture point, so a bench or on-chip loopback can confirm that displayed colors decode back to the source disparity/index stream.

## Interface
Parameters:
- TOL, 4: maximum allowed spread (max−min of the three per-channel estimates) for a pixel to count as a match; range 0..255.
- CNT_W, 16: width of the mismatch counters.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_sof  in  1  input pixel is the first pixel of a frame.
- in_r, in_g, in_b  in  8 each  input color.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_sof  out  1  delayed in_sof.
- out_h  out  8  decoded index.
- out_mismatch  out  1  spread > TOL.
- out_spread  out  8  max−min of the three estimates.
- err_count  out  CNT_W  mismatches so far in the current frame.
- err_frame  out  CNT_W  final mismatch count of the previous frame.

## Operation
- Forward map being inverted:
  - R = H
  - G = H[7] ? ~{H[6:0],0} : {H[6:0],0}
  - B = ~H
- Stage 1 (estimates):
  - hR = in_r
  - hB = ~in_b
  - hG = in_g[0] ? {1, ~in_g[7:1]} : {0, in_g[7:1]}
  - Register the three estimates and sof.
- Stage 2 (sort): register the median, max, and min of {hR, hG, hB}. All compares are 8-bit unsigned.
- Stage 3 (output):
  - out_h = median
  - out_spread = max − min (8-bit, never negative)
  - out_mismatch = (spread > TOL)
- Error counting, on each output transfer (out_valid & out_ready):
  - If out_sof = 1: err_frame ← err_count, then err_count ← out_mismatch. Both happen in the same cycle; the sof beat belongs to the new frame.
  - Otherwise: err_count ← err_count + out_mismatch, saturating at all-ones.
  - A frame with no sof yet accumulates into err_count normally.
- No state machine beyond the pipeline valids and counters. Every pixel yields exactly one output beat, in order.

## Timing
- Latency: 3 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: one pixel per cycle.
- Stall rule: the whole pipeline advances when en = !v3 | out_ready, where v1..v3 are the stage valids.
  - in_ready = en. This is combinational from out_ready and v3; there is no combinational path from in_valid.
  - When en = 1: stage k loads from stage k−1, and v1 ← in_valid.
  - Empty stages load bubbles (valid 0) and are not counted.
- Output hold: while out_valid = 1 and out_ready = 0, every out_* signal holds stable.
- Reset (async assert, leaves on the first clock after deassert):
  - v1..v3, out_valid, out_sof, out_mismatch = 0
  - out_h, out_spread = 0
  - err_count, err_frame = 0
  - in_ready = 1 (empty pipeline)
- Reset mid-frame drops all in-flight pixels; nothing is emitted for them.
- Saturation: err_count stays at 2^CNT_W−1 once reached until the next sof transfer. err_frame captures the saturated value.
- sof together with a mismatch in the same beat: err_frame gets the old count and err_count becomes 1.

## Test plan
- Clean sweep: drive H = 0x00..0xFF encoded by the forward map, back-to-back, out_ready = 1.
  - out_h equals H, 3 cycles later; spread = 0; mismatch = 0.
  - Spot values: (00,00,FF)→00; (80,FF,7F)→80; (C5,75,3A)→C5.
- Corrupt pixel: (50,20,EF), TOL = 4.
  - Estimates are 50/10/10 → out_h = 10, spread = 0x40, mismatch = 1, err_count increments.
- Tolerance edge, TOL = 4:
  - (14,20,EF) gives spread 4 → mismatch = 0.
  - (15,20,EF) gives spread 5 → mismatch = 1.
- Backpressure: random out_ready at 50% over 1000 pixels.
  - Output sequence is identical to the unstalled run.
  - Outputs stay stable while stalled; no loss or duplication.
  - in_ready = 0 only when v3 & !out_ready.
- Frame accounting: frame A has 3 mismatches; then frame B starts with a mismatched sof pixel.
  - At the B sof transfer: err_frame = 3, err_count = 1.
  - Also drive 2^CNT_W + 5 mismatches with CNT_W = 4: err_count saturates at 15.
- Async reset with 3 pixels in flight and out_ready = 0.
  - All valids clear immediately; counters = 0; in_ready = 1 after reset.
  - No stale beat appears afterwards.
